// File: rtl/r2b_converter.sv
// Row-to-block reorder buffer for the multi-MAC core array.
// Collects one stripe of BLOCK_SIZE*NUM_CORES_V matrix rows, then emits the
// stripe as block-ordered words (one BLOCK_SIZE x BLOCK_SIZE block per core)
// under downstream backpressure. Fill and emit never overlap.
module r2b_converter #(
    parameter int WIDTH       = 16,
    parameter int FRAC_WIDTH  = 8,
    parameter int ROW         = 256,
    parameter int COL         = 64,
    parameter int BLOCK_SIZE  = 2,
    parameter int CHUNK_SIZE  = 4,
    parameter int NUM_CORES_H = 2,
    parameter int NUM_CORES_V = 2
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   en,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [WIDTH*COL-1:0]                                   in_data,
    input  logic                                                   out_ready,
    output logic                                                   out_valid,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES_H*NUM_CORES_V-1:0]    out_data,
    output logic                                                   out_last,
    output logic                                                   stripe_done,
    output logic                                                   done
);

    // Rows per stripe, words per stripe, stripes per matrix.
    localparam int SR = BLOCK_SIZE * NUM_CORES_V;
    localparam int SC = COL / (BLOCK_SIZE * NUM_CORES_H);
    localparam int NS = ROW / SR;

    localparam int RW = (SR > 1) ? $clog2(SR) : 1;
    localparam int CW = (SC > 1) ? $clog2(SC) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    // Elaboration-time guards on the geometry; FRAC_WIDTH only has to fit in an element.
    if (ROW % SR != 0) begin : g_row_check
        $error("r2b_converter: ROW must be divisible by BLOCK_SIZE*NUM_CORES_V");
    end
    if (COL % (BLOCK_SIZE * NUM_CORES_H) != 0) begin : g_col_check
        $error("r2b_converter: COL must be divisible by BLOCK_SIZE*NUM_CORES_H");
    end
    if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_chunk_check
        $error("r2b_converter: CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
    end
    if (FRAC_WIDTH > WIDTH) begin : g_frac_check
        $error("r2b_converter: FRAC_WIDTH must not exceed WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_EMIT,
        S_DONE
    } state_t;

    state_t               state;
    logic [RW-1:0]        row_cnt;
    logic [CW-1:0]        col_cnt;
    logic [SW-1:0]        stripe_cnt;
    logic [WIDTH*COL-1:0] row_buf [SR];

    logic in_xfer;
    logic out_xfer;
    logic last_row;
    logic last_col;
    logic last_stripe;

    // Handshakes are gated by en directly so a frozen cycle never advertises a transfer.
    always_comb begin
        in_ready    = en && (state == S_FILL);
        out_valid   = en && (state == S_EMIT);
        in_xfer     = in_valid && in_ready;
        out_xfer    = out_valid && out_ready;
        last_row    = (row_cnt == RW'(SR - 1));
        last_col    = (col_cnt == CW'(SC - 1));
        last_stripe = (stripe_cnt == SW'(NS - 1));
        out_last    = out_valid && last_col && last_stripe;
    end

    // Control FSM, counters and stripe buffer; en=0 holds everything except the stripe_done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            row_cnt     <= '0;
            col_cnt     <= '0;
            stripe_cnt  <= '0;
            stripe_done <= 1'b0;
            done        <= 1'b0;
            // NOTE: the stripe buffer is cleared on reset so out_data returns to zero;
            // a buffer that need not read back clean would normally be left unreset.
            for (int i = 0; i < SR; i++) begin
                row_buf[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every read below sees
            // the pre-edge value and the default pulse clear is overridden cleanly.
            stripe_done <= 1'b0;
            if (en) begin
                case (state)
                    S_IDLE: begin
                        state <= S_FILL;
                    end
                    S_FILL: begin
                        if (in_xfer) begin
                            row_buf[row_cnt] <= in_data;
                            if (last_row) begin
                                row_cnt <= '0;
                                state   <= S_EMIT;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end
                    end
                    S_EMIT: begin
                        if (out_xfer) begin
                            if (last_col) begin
                                col_cnt     <= '0;
                                stripe_done <= 1'b1;
                                if (last_stripe) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    stripe_cnt <= stripe_cnt + 1'b1;
                                    state      <= S_FILL;
                                end
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        done <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Block-order word: core (v,h) gets rows v*BS.., columns of column group col_cnt.
    always_comb begin
        int col_base;
        col_base = int'(col_cnt) * BLOCK_SIZE * NUM_CORES_H;
        out_data = '0;
        for (int v = 0; v < NUM_CORES_V; v++) begin
            for (int h = 0; h < NUM_CORES_H; h++) begin
                for (int r = 0; r < BLOCK_SIZE; r++) begin
                    for (int k = 0; k < BLOCK_SIZE; k++) begin
                        out_data[((v*NUM_CORES_H + h)*CHUNK_SIZE + r*BLOCK_SIZE + k)*WIDTH +: WIDTH] =
                            row_buf[v*BLOCK_SIZE + r][(col_base + h*BLOCK_SIZE + k)*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_r2b_converter.sv
// Self-checking bench for r2b_converter: scoreboard of expected block-ordered
// words, filled as each stripe's last row is accepted and drained at the output.
module tb_r2b_converter;

    localparam int WIDTH       = 16;
    localparam int FRAC_WIDTH  = 8;
    localparam int ROW         = 8;
    localparam int COL         = 8;
    localparam int BLOCK_SIZE  = 2;
    localparam int CHUNK_SIZE  = 4;
    localparam int NUM_CORES_H = 2;
    localparam int NUM_CORES_V = 2;
    localparam int SR = BLOCK_SIZE * NUM_CORES_V;
    localparam int SC = COL / (BLOCK_SIZE * NUM_CORES_H);
    localparam int NS = ROW / SR;
    localparam int NW = NS * SC;
    localparam int OW = WIDTH * CHUNK_SIZE * NUM_CORES_H * NUM_CORES_V;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic [WIDTH*COL-1:0] in_data = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [OW-1:0]        out_data;
    logic                 out_last;
    logic                 stripe_done;
    logic                 done;

    r2b_converter #(
        .WIDTH(WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .ROW(ROW), .COL(COL),
        .BLOCK_SIZE(BLOCK_SIZE), .CHUNK_SIZE(CHUNK_SIZE),
        .NUM_CORES_H(NUM_CORES_H), .NUM_CORES_V(NUM_CORES_V)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .stripe_done(stripe_done), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [OW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            words_seen = 0;
    int            stripe_pulses = 0;
    int            rows_acc = 0;
    logic [OW-1:0] cap [NW];

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] elem(input int r, input int c);
        return WIDTH'(r * 16 + c);
    endfunction

    function automatic logic [WIDTH*COL-1:0] row_data(input int r);
        logic [WIDTH*COL-1:0] d;
        d = '0;
        for (int c = 0; c < COL; c++) d[c*WIDTH +: WIDTH] = elem(r, c);
        return d;
    endfunction

    // Expected word from the matrix coordinates of each element slot.
    function automatic logic [OW-1:0] exp_word(input int idx);
        logic [OW-1:0] w;
        int sr, sc, p;
        w  = '0;
        sr = idx / SC;
        sc = idx % SC;
        for (int v = 0; v < NUM_CORES_V; v++)
            for (int h = 0; h < NUM_CORES_H; h++)
                for (int r = 0; r < BLOCK_SIZE; r++)
                    for (int k = 0; k < BLOCK_SIZE; k++) begin
                        p = (v*NUM_CORES_H + h)*CHUNK_SIZE + r*BLOCK_SIZE + k;
                        w[p*WIDTH +: WIDTH] = elem(sr*SR + v*BLOCK_SIZE + r,
                                                   sc*BLOCK_SIZE*NUM_CORES_H + h*BLOCK_SIZE + k);
                    end
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] slot(input logic [OW-1:0] w, input int p);
        return w[p*WIDTH +: WIDTH];
    endfunction

    // Output monitor: scoreboard compare, stall stability, enable gating, pulse shape.
    bit            prev_stall = 1'b0;
    bit            last_seen = 1'b0;
    bit            prev_sd = 1'b0;
    logic [OW-1:0] prev_data = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            last_seen  = 1'b0;
            prev_sd    = 1'b0;
        end else begin
            if (last_seen) begin
                check("done_after_last", done, 1);
                last_seen = 1'b0;
            end
            if (stripe_done) begin
                stripe_pulses++;
                check("stripe_done_width", prev_sd, 0);
            end
            prev_sd = stripe_done;
            if (!en) begin
                check("en0_out_valid", out_valid, 0);
                check("en0_in_ready", in_ready, 0);
            end
            if (out_valid) begin
                check("in_ready_in_emit", in_ready, 0);
                if (prev_stall) check("stall_data_stable", out_data, prev_data);
                if (out_ready) begin
                    check("sb_has_word", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("word_data", out_data, e.data);
                        check("word_last", out_last, e.last);
                        if (e.last) last_seen = 1'b1;
                    end
                    if (words_seen < NW) cap[words_seen] = out_data;
                    words_seen++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = out_data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n         = 1'b1;
        words_seen    = 0;
        stripe_pulses = 0;
        rows_acc      = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_stripe_done"}, stripe_done, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_out_data"}, out_data, 0);
        @(posedge clk);
        #1;
    endtask

    // Drive rows r0..r1; push a stripe's expected words once its last row is accepted.
    task automatic feed(input int r0, input int r1, input int gap_pct, input bit check_lat);
        bit   accepted;
        exp_t e;
        int   idx;
        for (int r = r0; r <= r1; r++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = row_data(r);
            accepted = 1'b0;
            for (int t = 0; t < 300 && !accepted; t++) begin
                @(negedge clk);
                accepted = en && in_ready;
                @(posedge clk);
                #1;
            end
            check("row_accepted", accepted, 1);
            rows_acc++;
            if (r % SR == SR - 1) begin
                for (int s = 0; s < SC; s++) begin
                    idx    = (r / SR) * SC + s;
                    e.data = exp_word(idx);
                    e.last = (idx == NW - 1);
                    sb.push_back(e);
                end
                if (check_lat) begin
                    @(negedge clk);
                    check("latency_out_valid", out_valid, 1);
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() > 0 || !done) && t < 600) begin
            tick();
            t++;
        end
        check("drain_empty", sb.size(), 0);
        check("drain_done", done, 1);
    endtask

    int w0_exp [12] = '{'h00, 'h01, 'h10, 'h11, 'h02, 'h03, 'h12, 'h13, 'h20, 'h21, 'h30, 'h31};

    initial begin
        // Reset state.
        rst_n = 1'b0;
        tick();
        check_reset_outputs("reset");
        do_reset();

        // Basic ordering, back-to-back rows, no backpressure.
        en        = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        feed(0, ROW - 1, 0, 1'b1);
        drain();
        tick();
        check("basic_words", words_seen, NW);
        check("basic_stripe_pulses", stripe_pulses, NS);
        for (int i = 0; i < 12; i++) check("word0_elem", slot(cap[0], i), w0_exp[i]);
        check("word1_elem0", slot(cap[1], 0), 'h04);
        check("word2_elem0", slot(cap[2], 0), 'h40);
        check("word3_elem15", slot(cap[3], 15), 'h77);

        // Backpressure: out_ready low five cycles out of every six.
        do_reset();
        en = 1'b1;
        fork
            feed(0, ROW - 1, 0, 1'b0);
            begin
                for (int t = 0; t < 800 && !done; t++) begin
                    out_ready = (t % 6 == 5);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_words", words_seen, NW);

        // Random input gaps plus en=0 for 3 cycles mid-FILL and mid-EMIT.
        do_reset();
        en        = 1'b1;
        out_ready = 1'b1;
        fork
            feed(0, ROW - 1, 30, 1'b0);
            begin
                for (int t = 0; t < 300 && rows_acc < 2; t++) tick();
                en = 1'b0;
                repeat (3) tick();
                en = 1'b1;
                for (int t = 0; t < 300 && !out_valid; t++) tick();
                tick();
                en = 1'b0;
                repeat (3) tick();
                en = 1'b1;
            end
        join
        drain();
        check("en_words", words_seen, NW);

        // Reset mid-stream after two words, with the second stripe partly filled.
        do_reset();
        en        = 1'b1;
        out_ready = 1'b1;
        feed(0, SR + 1, 0, 1'b0);
        check("mid_words_before_reset", words_seen, 2);
        rst_n = 1'b0;
        sb.delete();
        tick();
        check_reset_outputs("midreset");
        rst_n         = 1'b1;
        words_seen    = 0;
        stripe_pulses = 0;
        feed(0, ROW - 1, 0, 1'b0);
        drain();
        check("refeed_words", words_seen, NW);
        check("refeed_word0", cap[0], exp_word(0));

        // DONE hold: inputs and en toggling do not leave DONE.
        in_valid = 1'b1;
        in_data  = row_data(0);
        for (int i = 0; i < 8; i++) begin
            en = i[0];
            @(negedge clk);
            check("done_hold_in_ready", in_ready, 0);
            check("done_hold_out_valid", out_valid, 0);
            check("done_hold_done", done, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        @(negedge clk);
        check("done_cleared_by_reset", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
